mem_region_arbiter: RTL

MEM_REGION_ARBITER -- requirements
Module: mem_region_arbiter

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/mem_region_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-region arbiter: FSM states,
// requester IDs and small one-hot/index helpers.
package mem_arb_pkg;

    localparam int NREQ      = 3;
    localparam int REQ_IDX_W = 2;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_CPU    = 1;
    localparam int REQ_HOST   = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_ERR_RSP  = 3'd4
    } state_e;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [REQ_IDX_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = REQ_IDX_W'(i);
        end
        return idx;
    endfunction

    // Wraps NREQ-1 back to 0 so the pointer never leaves the requester range.
    function automatic logic [REQ_IDX_W-1:0] next_idx(input logic [REQ_IDX_W-1:0] idx);
        return (idx == REQ_IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from 'pointer' upward (with
// wrap) and grants the first requester found, one-hot.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N     = NREQ,
    parameter int PTR_W = REQ_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] pointer,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = pointer;
        for (int i = 0; i < N; i++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_region_arbiter.sv
// Arbitrates three requesters onto one memory port, one transaction at a time,
// rejecting accesses that fall outside each requester's permitted region.
module mem_region_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      im_bottom,
    input  logic [ADDR_W-1:0]      im_top,
    input  logic [ADDR_W-1:0]      dm_bottom,
    input  logic [ADDR_W-1:0]      dm_top,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [DATA_W-1:0]      mem_rsp_data,
    output logic [15:0]            viol_count,
    output logic                   timeout_flag,
    output logic                   spurious_flag,
    output logic [2:0]             dbg_state
);

    // Handshake: a requester holds req_valid and its payload steady until it
    // sees req_ready (IDLE only, one cycle); downstream, mem_req_valid holds
    // with a stable payload until mem_req_ready is sampled high.

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [REQ_IDX_W-1:0]   ptr_q, ptr_d;
    logic [REQ_IDX_W-1:0]   id_q, id_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [15:0]            viol_q, viol_d;
    logic                   timeout_q, timeout_d;
    logic                   spurious_q, spurious_d;

    logic [NREQ-1:0]        grant;
    logic [REQ_IDX_W-1:0]   grant_idx;
    logic [ADDR_W:0]        end_addr;
    logic                   carry;
    logic                   im_ok, dm_ok, legal;

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (REQ_IDX_W)
    ) u_rr (
        .req     (req_valid),
        .pointer (ptr_q),
        .grant   (grant)
    );

    assign grant_idx = onehot_to_idx(grant);

    // Last byte address carries one extra bit so a wrap past the top of the
    // address space shows up as a violation instead of a small address.
    assign end_addr = {1'b0, addr_q} + (ADDR_W + 1)'(BYTES - 1);
    assign carry    = end_addr[ADDR_W];
    assign im_ok    = !carry && (im_bottom <= im_top) && (im_bottom <= addr_q)
                      && (end_addr[ADDR_W-1:0] <= im_top);
    assign dm_ok    = !carry && (dm_bottom <= dm_top) && (dm_bottom <= addr_q)
                      && (end_addr[ADDR_W-1:0] <= dm_top);

    always_comb begin
        legal = 1'b0;
        case (id_q)
            REQ_IDX_W'(REQ_IFETCH): legal = !we_q && im_ok;
            REQ_IDX_W'(REQ_CPU):    legal = dm_ok;
            REQ_IDX_W'(REQ_HOST):   legal = im_ok || dm_ok;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        viol_d      = viol_q;
        timeout_d   = timeout_q;
        spurious_d  = spurious_q;
        req_ready   = '0;

        if (mem_rsp_valid && (state_q != ST_WAIT_RSP)) spurious_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready = reset ? '0 : grant;
                    id_d      = grant_idx;
                    we_d      = req_we[grant_idx];
                    addr_d    = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                    ptr_d     = next_idx(grant_idx);
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (legal) begin
                    state_d = ST_ISSUE;
                end else begin
                    // Error pulse is registered so it is visible during ERR_RSP.
                    rsp_valid_d = idx_to_onehot(id_q);
                    rsp_err_d   = 1'b1;
                    viol_d      = (viol_q == 16'hFFFF) ? viol_q : viol_q + 16'd1;
                    state_d     = ST_ERR_RSP;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    rsp_valid_d = idx_to_onehot(id_q);
                    rsp_data_d  = mem_rsp_data;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = idx_to_onehot(id_q);
                    rsp_err_d   = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            viol_q      <= '0;
            timeout_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            viol_q      <= viol_d;
            timeout_q   <= timeout_d;
            spurious_q  <= spurious_d;
        end
    end

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign viol_count    = viol_q;
    assign timeout_flag  = timeout_q;
    assign spurious_flag = spurious_q;
    assign dbg_state     = state_q;

endmodule
